// File: rtl/hdmi_packet_scheduler.sv
// Chooses the data-island packet type for each hdmi packet slot and drives the audio buffer pop.
// packet_type and audio_pop are registered: they update on the edge after packet_enable.
module hdmi_packet_scheduler #(
  parameter int         BIT_WIDTH    = 10,
  parameter int         SPD_PERIOD   = 16,
  parameter logic [7:0] AUDIO_URGENT = 8'd24
) (
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic [BIT_WIDTH-1:0] cy,
  input  logic                 packet_enable,
  input  logic                 audio_enable,
  input  logic [7:0]           audio_remaining,
  output logic [7:0]           packet_type,
  output logic                 audio_pop,
  output logic                 frame_overrun
);

  localparam logic [7:0] PT_NULL  = 8'h00;
  localparam logic [7:0] PT_ACR   = 8'h01;
  localparam logic [7:0] PT_AUDIO = 8'h02;
  localparam logic [7:0] PT_AVI   = 8'h82;
  localparam logic [7:0] PT_SPD   = 8'h83;
  localparam logic [7:0] PT_AIF   = 8'h84;
  localparam logic [7:0] CNT_LAST = 8'(SPD_PERIOD - 1);

  logic       p_acr_q, p_acr_d;
  logic       p_avi_q, p_avi_d;
  logic       p_aif_q, p_aif_d;
  logic       p_spd_q, p_spd_d;
  logic       started_q, started_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] type_q, type_d;
  logic       pop_q, pop_d;
  logic       overrun_q, overrun_d;

  logic       frame_start;
  logic       acr_eff, avi_eff, aif_eff, spd_eff;
  logic       urgent, has_audio, active;
  logic       sel_acr, sel_avi, sel_aif, sel_spd, sel_audio;
  logic [7:0] sel_type;

  assign frame_start = (cx == '0) && (cy == '0);
  assign urgent      = audio_enable && (audio_remaining >= AUDIO_URGENT);
  assign has_audio   = audio_enable && (audio_remaining != 8'd0);
  assign active      = started_q || frame_start;

  // Flag view after the frame-start reload, so a coincident slot sees the fresh set.
  always_comb begin
    acr_eff = audio_enable && (p_acr_q || frame_start);
    aif_eff = audio_enable && (p_aif_q || frame_start);
    avi_eff = p_avi_q || frame_start;
    spd_eff = p_spd_q || (frame_start && (frame_cnt_q == 8'd0));
  end

  always_comb begin
    sel_acr   = 1'b0;
    sel_avi   = 1'b0;
    sel_aif   = 1'b0;
    sel_spd   = 1'b0;
    sel_audio = 1'b0;
    sel_type  = PT_NULL;
    if (active) begin
      if (urgent) begin
        sel_audio = 1'b1;
        sel_type  = PT_AUDIO;
      end else if (acr_eff) begin
        sel_acr  = 1'b1;
        sel_type = PT_ACR;
      end else if (avi_eff) begin
        sel_avi  = 1'b1;
        sel_type = PT_AVI;
      end else if (aif_eff) begin
        sel_aif  = 1'b1;
        sel_type = PT_AIF;
      end else if (spd_eff) begin
        sel_spd  = 1'b1;
        sel_type = PT_SPD;
      end else if (has_audio) begin
        sel_audio = 1'b1;
        sel_type  = PT_AUDIO;
      end
    end
  end

  always_comb begin
    p_acr_d     = acr_eff && !(packet_enable && sel_acr);
    p_aif_d     = aif_eff && !(packet_enable && sel_aif);
    p_avi_d     = avi_eff && !(packet_enable && sel_avi);
    p_spd_d     = spd_eff && !(packet_enable && sel_spd);
    started_d   = active;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    type_d      = type_q;
    pop_d       = packet_enable && sel_audio;
    if (frame_start) begin
      frame_cnt_d = (frame_cnt_q >= CNT_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
      // Audio flags already dropped by a disabled audio path are not overruns.
      if (p_avi_q || (audio_enable && (p_acr_q || p_aif_q)))
        overrun_d = 1'b1;
    end
    if (packet_enable)
      type_d = sel_type;
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      p_acr_q     <= 1'b0;
      p_avi_q     <= 1'b0;
      p_aif_q     <= 1'b0;
      p_spd_q     <= 1'b0;
      started_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      type_q      <= PT_NULL;
      pop_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      p_acr_q     <= p_acr_d;
      p_avi_q     <= p_avi_d;
      p_aif_q     <= p_aif_d;
      p_spd_q     <= p_spd_d;
      started_q   <= started_d;
      frame_cnt_q <= frame_cnt_d;
      type_q      <= type_d;
      pop_q       <= pop_d;
      overrun_q   <= overrun_d;
    end
  end

  assign packet_type   = type_q;
  assign audio_pop     = pop_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed vectors for hdmi_packet_scheduler with SPD_PERIOD = 4.
module tb_hdmi_packet_scheduler;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic [9:0] cx, cy;
  logic       packet_enable, audio_enable;
  logic [7:0] audio_remaining;
  logic [7:0] packet_type;
  logic       audio_pop, frame_overrun;

  int n_vec = 0;
  int n_err = 0;

  hdmi_packet_scheduler #(
    .BIT_WIDTH(10),
    .SPD_PERIOD(4),
    .AUDIO_URGENT(8'd24)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .cx(cx),
    .cy(cy),
    .packet_enable(packet_enable),
    .audio_enable(audio_enable),
    .audio_remaining(audio_remaining),
    .packet_type(packet_type),
    .audio_pop(audio_pop),
    .frame_overrun(frame_overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    bit         rst_n;
    bit         fs;
    bit         pe;
    bit         ae;
    logic [7:0] rem;
    logic [7:0] exp_type;
    bit         exp_pop;
    bit         exp_ovr;
  } vec_t;

  vec_t vq[$];
  bit   eo;

  task automatic add(input bit r, input bit f, input bit p, input bit a,
                     input logic [7:0] rem, input logic [7:0] et, input bit ep);
    vec_t v;
    v.rst_n = r; v.fs = f; v.pe = p; v.ae = a; v.rem = rem;
    v.exp_type = et; v.exp_pop = ep; v.exp_ovr = eo;
    vq.push_back(v);
  endtask

  task automatic cyc(input bit r, input bit f, input bit p, input bit a, input logic [7:0] rem);
    reset_n         = r;
    cx              = f ? 10'd0 : 10'd7;
    cy              = f ? 10'd0 : 10'd7;
    packet_enable   = p;
    audio_enable    = a;
    audio_remaining = rem;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h", nm, got, exp);
    end
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

    eo = 1'b0;
    add(0,0,0,1,8'd0, 8'h00,0);
    add(0,0,0,1,8'd0, 8'h00,0);
    // before the first frame start only nulls go out
    add(1,0,1,1,8'd30,8'h00,0);
    add(1,0,0,1,8'd30,8'h00,0);
    // frame 0: counter 0, SPD due
    add(1,1,0,1,8'd0, 8'h00,0);
    add(1,0,1,1,8'd0, 8'h01,0); add(1,0,0,1,8'd0, 8'h01,0);
    add(1,0,1,1,8'd0, 8'h82,0); add(1,0,0,1,8'd0, 8'h82,0);
    add(1,0,1,1,8'd0, 8'h84,0); add(1,0,1,1,8'd0, 8'h83,0);
    add(1,0,1,1,8'd0, 8'h00,0); add(1,0,1,1,8'd0, 8'h00,0);
    // frame 1: urgent audio first
    add(1,1,0,1,8'd30,8'h00,0);
    add(1,0,1,1,8'd30,8'h02,1); add(1,0,0,1,8'd30,8'h02,0);
    add(1,0,1,1,8'd30,8'h02,1); add(1,0,1,1,8'd30,8'h02,1);
    add(1,0,1,1,8'd5, 8'h01,0); add(1,0,1,1,8'd5, 8'h82,0);
    add(1,0,1,1,8'd5, 8'h84,0); add(1,0,1,1,8'd5, 8'h02,1);
    add(1,0,0,1,8'd5, 8'h02,0);
    // frame 2: no slots offered
    add(1,1,0,1,8'd0, 8'h02,0); add(1,0,0,1,8'd0, 8'h02,0);
    // frame 3: pending mandatory packets at frame start
    eo = 1'b1;
    add(1,1,0,1,8'd0, 8'h02,0);
    add(1,0,1,1,8'd0, 8'h01,0); add(1,0,1,1,8'd0, 8'h82,0);
    add(1,0,1,1,8'd0, 8'h84,0); add(1,0,1,1,8'd0, 8'h00,0);
    // frame 4: audio disabled, SPD due
    add(1,1,0,0,8'd10,8'h00,0);
    add(1,0,1,0,8'd10,8'h82,0); add(1,0,1,0,8'd10,8'h83,0);
    add(1,0,1,0,8'd10,8'h00,0); add(1,0,1,0,8'd10,8'h00,0);
    // frame 5: audio_enable drops for one cycle mid-frame
    add(1,1,0,1,8'd0, 8'h00,0);
    add(1,0,1,1,8'd0, 8'h01,0); add(1,0,0,0,8'd0, 8'h01,0);
    add(1,0,0,1,8'd0, 8'h01,0);
    add(1,0,1,1,8'd0, 8'h82,0); add(1,0,1,1,8'd0, 8'h00,0);
    // frame 6: frame start coincident with a slot
    add(1,1,1,1,8'd0, 8'h01,0);
    add(1,0,1,1,8'd0, 8'h82,0); add(1,0,1,1,8'd0, 8'h84,0);
    add(1,0,1,1,8'd0, 8'h00,0);
    // frame 7: no SPD
    add(1,1,0,1,8'd0, 8'h00,0);
    add(1,0,1,1,8'd0, 8'h01,0); add(1,0,1,1,8'd0, 8'h82,0);
    add(1,0,1,1,8'd0, 8'h84,0); add(1,0,1,1,8'd0, 8'h00,0);
    // frame 8: SPD again
    add(1,1,0,1,8'd0, 8'h00,0);
    add(1,0,1,1,8'd0, 8'h01,0); add(1,0,1,1,8'd0, 8'h82,0);
    add(1,0,1,1,8'd0, 8'h84,0); add(1,0,1,1,8'd0, 8'h83,0);
    add(1,0,1,1,8'd0, 8'h00,0);
    // frame 9: reset mid-frame with a slot and urgent audio on that edge
    add(1,1,0,1,8'd0, 8'h00,0);
    add(1,0,1,1,8'd0, 8'h01,0);
    eo = 1'b0;
    add(0,0,1,1,8'd30,8'h00,0);
    add(1,0,1,1,8'd30,8'h00,0);
    add(1,0,0,1,8'd0, 8'h00,0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rst_n, vq[i].fs, vq[i].pe, vq[i].ae, vq[i].rem);
      n_vec++;
      if (packet_type !== vq[i].exp_type || audio_pop !== vq[i].exp_pop ||
          frame_overrun !== vq[i].exp_ovr) begin
        n_err++;
        $display("FAIL vec%0d: type %02h want %02h, pop %0d want %0d, ovr %0d want %0d",
                 i, packet_type, vq[i].exp_type, audio_pop, vq[i].exp_pop,
                 frame_overrun, vq[i].exp_ovr);
      end
    end

    // Urgency threshold boundary, then a long slot-free frame.
    cyc(1, 1, 0, 1, 8'd23);
    chk("thr_fs_ovr", {7'd0, frame_overrun}, 8'h00);
    cyc(1, 0, 1, 1, 8'd23);
    chk("thr_23_type", packet_type, 8'h01);
    chk("thr_23_pop", {7'd0, audio_pop}, 8'h00);
    cyc(1, 0, 1, 1, 8'd24);
    chk("thr_24_type", packet_type, 8'h02);
    chk("thr_24_pop", {7'd0, audio_pop}, 8'h01);
    for (int i = 0; i < 35; i++) begin
      cyc(1, 0, 0, 1, 8'd24);
      chk("idle_pop", {7'd0, audio_pop}, 8'h00);
      chk("idle_hold", packet_type, 8'h02);
      chk("idle_ovr", {7'd0, frame_overrun}, 8'h00);
    end

    // AVI/AIF still pending at this frame start: overrun sets and sticks.
    cyc(1, 1, 0, 1, 8'd0);
    chk("ovr_set", {7'd0, frame_overrun}, 8'h01);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, (i % 8) == 0, 1, 8'd0);
      chk("ovr_sticky", {7'd0, frame_overrun}, 8'h01);
    end
    cyc(0, 0, 0, 1, 8'd0);
    chk("ovr_reset", {7'd0, frame_overrun}, 8'h00);
    chk("type_reset", packet_type, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hdmi_packet_scheduler.md
# hdmi_packet_scheduler

Selects the HDMI data-island packet type for every packet slot the `hdmi` core offers, in the `clk_pixel` domain. Guarantees once-per-frame delivery of Audio Clock Regeneration, AVI InfoFrame and Audio InfoFrame, and periodic delivery of the SPD InfoFrame. Keeps the audio sample buffer drained, with an urgency override that prevents overflow. Sits between the audio `buffer` (reads `remaining`, drives its pop) and the `hdmi` core (consumes `packet_type`, produces `packet_enable`, `cx`, `cy`).

## Interface
Parameters:
- `BIT_WIDTH`, 10, width of `cx`/`cy`
- `SPD_PERIOD`, 16, frames between SPD InfoFrames (legal range 1..255)
- `AUDIO_URGENT`, 8'd24, `audio_remaining` level at or above which audio samples pre-empt all InfoFrames

Ports:
- `clk_pixel`  in  1  pixel clock; only clock
- `reset_n`  in  1  synchronous, active-low reset
- `cx`  in  BIT_WIDTH  current pixel column from `hdmi`
- `cy`  in  BIT_WIDTH  current line from `hdmi`
- `packet_enable`  in  1  one-cycle pulse: `hdmi` latches the next packet type
- `audio_enable`  in  1  when 0, no ACR, Audio InfoFrame or sample packets are scheduled
- `audio_remaining`  in  8  samples waiting in the audio buffer
- `packet_type`  out  8  0x00 null, 0x01 ACR, 0x02 audio sample, 0x82 AVI, 0x83 SPD, 0x84 Audio IF
- `audio_pop`  out  1  one-cycle pulse; the buffer releases one sample packet
- `frame_overrun`  out  1  sticky: a mandatory packet was still pending at a frame start

## Operation
- Frame start: the cycle with `cx == 0 && cy == 0`.
- Pending flags: `p_acr`, `p_avi`, `p_aif`, `p_spd`.
- Frame-start actions:
  - `p_avi` is set.
  - `p_acr` and `p_aif` are set when `audio_enable` = 1.
  - An 8-bit frame counter increments, wrapping from `SPD_PERIOD-1` to 0. `p_spd` is set when the counter reads 0 before the increment, so SPD is sent in the first frame after reset.
  - If any of `p_acr`, `p_avi` or `p_aif` is still set before the reload, `frame_overrun` is set. It is cleared only by reset.
  - A pending `p_spd` is carried over without being flagged.
- Selection on a `packet_enable` cycle, in priority order:
  1. `audio_enable && audio_remaining >= AUDIO_URGENT`: 0x02
  2. `p_acr`: 0x01
  3. `p_avi`: 0x82
  4. `p_aif && audio_enable`: 0x84
  5. `p_spd`: 0x83
  6. `audio_enable && audio_remaining > 0`: 0x02
  7. otherwise: 0x00
- The selected flag is cleared.
- A 0x02 selection pulses `audio_pop`.
- Frame start and `packet_enable` in the same cycle: selection uses the reloaded flag set, and the chosen flag ends the cycle cleared.
- `audio_enable` falling mid-frame:
  - `p_acr` and `p_aif` are cleared on the next cycle.
  - No overrun is counted for them.
- Reset:
  - All flags 0, frame counter 0.
  - `packet_type` = 0x00, `audio_pop` = 0, `frame_overrun` = 0.
  - Nothing is scheduled, except null packets, until the first frame start.

## Timing
- `packet_type` and `audio_pop` are registered. Both update on the edge after the `packet_enable` cycle (1-cycle latency).
- `packet_type` holds its value until the next `packet_enable`.
- `audio_pop` is high for exactly one cycle per 0x02 selection. It is never asserted without `packet_enable` on the preceding cycle.
- `packet_enable` pulses are at least 32 cycles apart (one packet duration). Back-to-back pulses are still handled: each pulse is evaluated independently.
- Reset is sampled only on the `clk_pixel` edge. Asserting it mid-frame drops all pending flags. `packet_type` returns to 0x00 on that same edge.

## Test plan
- Reset, then frame start with `audio_enable` = 1 and `audio_remaining` = 0, then 6 `packet_enable` pulses: `packet_type` sequence 0x01, 0x82, 0x84, 0x83, 0x00, 0x00; `audio_pop` never asserted.
- Frame start with `audio_remaining` = 30 for 3 pulses: three 0x02 packets and three `audio_pop` pulses, then 0x01, 0x82, 0x84 once `audio_remaining` is 5.
- With `SPD_PERIOD` = 4, run 9 frames with ample slots: 0x83 appears in frames 0, 4 and 8 only.
- Frame start with no `packet_enable` before the next frame start: `frame_overrun` = 1 one cycle after the second frame start. It stays 1 until `reset_n` = 0.
- `audio_enable` = 0 at frame start with `audio_remaining` = 10: only 0x82, 0x83, then 0x00; no `audio_pop`.
- Frame start coincident with `packet_enable`: `packet_type` = 0x01 on the next edge; the following pulse yields 0x82.
